// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one fixed-latency multiplier by N_REQ req/resp valid-ready channels (req_*_i/o, resp_*_i/o), driving mul_start_o/mul_a_o/mul_b_o, taking mul_result_i/mul_done_i, reporting busy_o and sticky err_sync_o
module mul_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ*WIDTH-1:0]   req_a_i,
  input  logic [N_REQ*WIDTH-1:0]   req_b_i,
  output logic [N_REQ-1:0]         resp_valid_o,
  input  logic [N_REQ-1:0]         resp_ready_i,
  output logic [N_REQ*2*WIDTH-1:0] resp_data_o,
  output logic                     mul_start_o,
  output logic [WIDTH-1:0]         mul_a_o,
  output logic [WIDTH-1:0]         mul_b_o,
  input  logic [2*WIDTH-1:0]       mul_result_i,
  input  logic                     mul_done_i,
  output logic                     busy_o,
  output logic                     err_sync_o
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, PEND, HOLD} st_t;
  st_t              state_q [N_REQ];
  logic [IW-1:0]    tag_id_q [MUL_LAT];
  logic [MUL_LAT-1:0] tag_v_q;
  logic [IW-1:0]    last_q, issue_id_q, gnt_id, idx, tail_id;
  logic [N_REQ-1:0] elig;
  logic             gnt_v, tail_v;
  assign tail_v  = tag_v_q[MUL_LAT-1];
  assign tail_id = tag_id_q[MUL_LAT-1];
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid_i[i] & (state_q[i] == IDLE);
      busy_o  = busy_o | (state_q[i] != IDLE);
    end
  end
  always_comb begin
    gnt_v = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_q) + k) % N_REQ);
      if (elig[idx]) begin
        gnt_v  = 1'b1;
        gnt_id = idx;
      end
    end
    req_ready_o = '0;
    req_ready_o[gnt_id] = gnt_v;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) state_q[i] <= IDLE;
      for (int s = 0; s < MUL_LAT; s++) tag_id_q[s] <= '0;
      tag_v_q      <= '0;
      last_q       <= IW'(N_REQ - 1);
      issue_id_q   <= '0;
      mul_start_o  <= 1'b0;
      mul_a_o      <= '0;
      mul_b_o      <= '0;
      resp_valid_o <= '0;
      resp_data_o  <= '0;
      err_sync_o   <= 1'b0;
    end else begin
      mul_start_o <= gnt_v;
      issue_id_q  <= gnt_id;
      tag_v_q[0]  <= mul_start_o;
      tag_id_q[0] <= issue_id_q;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end
      for (int i = 0; i < N_REQ; i++)
        if (resp_valid_o[i] & resp_ready_i[i]) begin
          resp_valid_o[i] <= 1'b0;
          state_q[i]      <= IDLE;
        end
      if (gnt_v) begin
        mul_a_o          <= req_a_i[gnt_id*WIDTH +: WIDTH];
        mul_b_o          <= req_b_i[gnt_id*WIDTH +: WIDTH];
        state_q[gnt_id]  <= PEND;
        last_q           <= gnt_id;
      end
      if (tail_v & mul_done_i) begin
        resp_data_o[tail_id*2*WIDTH +: 2*WIDTH] <= mul_result_i;
        resp_valid_o[tail_id] <= 1'b1;
        state_q[tail_id]      <= HOLD;
      end else if (tail_v) begin
        state_q[tail_id] <= IDLE;
      end
      err_sync_o <= err_sync_o | (tail_v ^ mul_done_i);
    end
  end
endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter and sequencer that shares one pipelined 8x8 multiplier among N requesters. Each requester gets a valid/ready request channel and a valid/ready response channel. The block issues at most one multiply per cycle and tracks each in-flight operation with a tag pipeline matched to the multiplier latency. It routes every product back to the requester that issued it. It sits between the client blocks and the multiplier's start/a/b/result/done ports.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand width; products are 2*WIDTH
- MUL_LAT, 3, cycles from mul_start high to mul_done high (fixed latency of the attached multiplier)

- clk  in  1  rising-edge clock, the only clock
- rst  in  1  synchronous, active-high reset; the attached multiplier must be reset in the same cycles
- req_valid  in  N_REQ  request present, per requester
- req_ready  out  N_REQ  request accepted this cycle (one-hot or zero)
- req_a, req_b  in  N_REQ*WIDTH  operands, requester i at bits [i*WIDTH +: WIDTH]
- resp_valid  out  N_REQ  product available, per requester
- resp_ready  in  N_REQ  requester consumes product
- resp_data  out  N_REQ*2*WIDTH  product, requester i at bits [i*2*WIDTH +: 2*WIDTH]
- mul_start  out  1  issue pulse to the multiplier
- mul_a, mul_b  out  WIDTH  operands to the multiplier
- mul_result  in  2*WIDTH  multiplier product
- mul_done  in  1  multiplier result strobe
- busy  out  1  any requester not in IDLE
- err_sync  out  1  sticky mismatch between mul_done and the tag pipeline

## Operation
- Each requester has a registered state:
  - IDLE → PEND on grant.
  - PEND → HOLD when its tag retires.
  - HOLD → IDLE on resp_valid & resp_ready.
- Each requester has at most one outstanding operation, so response slots never overflow.
- Eligible(i) = req_valid[i] & state[i]==IDLE. Eligibility uses the registered state only.
- Grant: the first eligible requester scanning upward from last_grant+1 (mod N_REQ). If none are eligible, there is no grant.
- req_ready[g] is asserted combinationally in the cycle of the grant. At that edge:
  - operands are captured into mul_a/mul_b
  - mul_start is set for one cycle
  - the tag {valid=1, id=g} is pushed into an MUL_LAT-deep shift register
  - last_grant is updated to g
- In cycles without a grant, mul_start=0 and a {valid=0} bubble is pushed. mul_a/mul_b hold their previous values.
- Tag retire (tail valid & mul_done): mul_result is registered into resp_data[id], resp_valid[id] is set, and state[id] becomes HOLD.
- resp_data is held stable while resp_valid is high.
- err_sync is set, and stays set until rst, in either case:
  - tail valid & !mul_done: that tag is dropped and its requester returns to IDLE with no response.
  - tail invalid & mul_done: the result is ignored.
- busy = OR over requesters of (state != IDLE).

## Timing
- Reset values: all outputs 0, all tags invalid, all states IDLE, last_grant = N_REQ-1 (requester 0 wins first).
- Requests accepted back to back: one grant per cycle, full multiplier throughput when distinct requesters are eligible.
- Latency: handshake at edge t → mul_start high in cycle t+1 → mul_done in cycle t+1+MUL_LAT → resp_valid high from cycle t+2+MUL_LAT. The minimum request-to-response time is MUL_LAT+2 cycles.
- A response handshake at edge t makes that requester eligible from cycle t+1. It is never eligible in the same cycle as its response handshake.
- resp_valid low-to-high does not depend on resp_ready. Responses wait indefinitely without blocking other requesters.
- Reset mid-operation:
  - all tags, states, responses and pointers clear at the reset edge
  - in-flight products are discarded
  - no err_sync is raised, because the multiplier is reset in the same cycles
- Simultaneous retire of requester i and a new request from i is impossible, because i is not IDLE.

## Test plan
- Single op, MUL_LAT=3:
  - Stimulus: requester 0 sends a=5, b=3.
  - Required: req_ready[0] in the request cycle, mul_start one cycle later, resp_data[0]=15 with resp_valid[0] 5 cycles after the handshake. busy is high from the grant until resp_ready.
- Contention:
  - Stimulus: all four requesters valid in the same cycle with (2,3), (4,6), (7,7), (255,255).
  - Required: grants in order 0,1,2,3 on consecutive cycles. Four back-to-back mul_start pulses. Responses 6, 24, 49, 65025 on consecutive cycles.
- Rotation:
  - Stimulus: requesters 1 and 3 re-request immediately after each response handshake.
  - Required: grants alternate 1,3,1,3. Requester 1 never receives two grants in a row while 3 is waiting.
- Response backpressure:
  - Stimulus: hold resp_ready[2]=0 for 10 cycles after requester 2 sends (9,9).
  - Required: resp_data[2]=81 stays stable. Requester 2's new req_valid gets no req_ready until the cycle after the response handshake. Other requesters continue to be served.
- Sync error:
  - Stimulus: force mul_done low on the expected cycle.
  - Required: err_sync rises and stays high, the requester returns to IDLE with no resp_valid, and an unsolicited mul_done leaves err_sync high.
- Reset mid-flight:
  - Stimulus: assert rst for 2 cycles with 3 operations in flight.
  - Required: all outputs 0 after the reset edge, no resp_valid afterward, err_sync=0. The next request from requester 0 completes normally.
